// File: rtl/common.sv
// Shared types for the integer divider: operation codes, data word and FSM state.
package common;

    localparam int unsigned XLEN = 64;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alufunc_t;

    typedef enum logic [1:0] {
        DivIdle,
        DivBusy,
        DivFix,
        DivDone
    } div_state_t;

    function automatic logic is_signed_op(alufunc_t f);
        return (f == ALU_DIV) || (f == ALU_REM);
    endfunction

    function automatic logic is_rem_op(alufunc_t f);
        return (f == ALU_REM) || (f == ALU_REMU);
    endfunction

    function automatic word_t sext32(logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic word_t ext32(logic [31:0] v, logic sgn);
        return sgn ? sext32(v) : {32'b0, v};
    endfunction

    // Final result selection; special cases override the iterative datapath.
    function automatic word_t div_result(logic rem, logic is_w, logic div0, logic ovf,
                                         word_t a_eff, word_t quot, word_t remd,
                                         logic q_neg, logic r_neg);
        word_t raw;
        if (div0) begin
            raw = rem ? a_eff : '1;
        end else if (ovf) begin
            raw = rem ? '0 : a_eff;
        end else if (rem) begin
            raw = r_neg ? -remd : remd;
        end else begin
            raw = q_neg ? -quot : quot;
        end
        return is_w ? sext32(raw[31:0]) : raw;
    endfunction

endpackage

// File: rtl/divider_if.sv
// Request/response bundle between the execute stage and the divider.
interface divider_if;

    logic            valid_in;
    logic            ready_out;
    logic            flush;
    common::alufunc_t func;
    logic            is_w;
    common::word_t   a;
    common::word_t   b;
    logic            done;
    common::word_t   result;

    modport master (
        output valid_in, flush, func, is_w, a, b,
        input  ready_out, done, result
    );

    modport slave (
        input  valid_in, flush, func, is_w, a, b,
        output ready_out, done, result
    );

endinterface

// File: rtl/div_iter.sv
// Unsigned restoring shift-subtract divider, one quotient bit per step.
module div_iter
    import common::*;
(
    input  logic  clk,
    input  logic  load_i,
    input  logic  step_i,
    input  logic  is_w_i,
    input  word_t dividend_i,
    input  word_t divisor_i,
    output word_t quot_o,
    output word_t rem_o
);

    word_t       quot_q, quot_d;
    word_t       rem_q, rem_d;
    word_t       divisor_q, divisor_d;
    logic [64:0] trial;

    always_comb begin
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        // Bit 64 set means the partial remainder was smaller than the divisor.
        trial     = {rem_q, quot_q[63]} - {1'b0, divisor_q};
        if (load_i) begin
            quot_d    = is_w_i ? {dividend_i[31:0], 32'b0} : dividend_i;
            rem_d     = '0;
            divisor_d = divisor_i;
        end else if (step_i) begin
            if (!trial[64]) begin
                rem_d  = trial[63:0];
                quot_d = {quot_q[62:0], 1'b1};
            end else begin
                rem_d  = {rem_q[62:0], quot_q[63]};
                quot_d = {quot_q[62:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        quot_q    <= quot_d;
        rem_q     <= rem_d;
        divisor_q <= divisor_d;
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/divider.sv
// Multi-cycle 64-bit divider: FSM, sign handling and special cases around div_iter.
// DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow complete 1 cycle after accept.
module divider
    import common::*;
#(
    parameter int unsigned XLEN = 64
) (
    input logic       clk,
    input logic       reset,
    divider_if.slave  bus
);

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FastSpecial = 1'b1;
`else
    localparam bit FastSpecial = 1'b0;
`endif

    div_state_t state_q;
    logic       ready_q, done_q;
    word_t      result_q;
    logic [5:0] cnt_q;
    logic       rem_q, is_w_q, div0_q, ovf_q, q_neg_q, r_neg_q;
    word_t      a_eff_q;

    logic       sgn_in, rem_in, a_neg, b_neg, div0_in, ovf_in, accept, fast;
    word_t      a_eff, b_eff, mag_a, mag_b, min_neg, fast_res, fix_res;
    word_t      quot, remd;
    logic [5:0] last_step;

    always_comb begin
        sgn_in   = is_signed_op(bus.func);
        rem_in   = is_rem_op(bus.func);
        a_eff    = bus.is_w ? ext32(bus.a[31:0], sgn_in) : bus.a;
        b_eff    = bus.is_w ? ext32(bus.b[31:0], sgn_in) : bus.b;
        a_neg    = sgn_in & a_eff[63];
        b_neg    = sgn_in & b_eff[63];
        mag_a    = a_neg ? -a_eff : a_eff;
        mag_b    = b_neg ? -b_eff : b_eff;
        min_neg  = bus.is_w ? sext32(32'h8000_0000) : {1'b1, 63'b0};
        div0_in  = (b_eff == '0);
        ovf_in   = sgn_in & (b_eff == '1) & (a_eff == min_neg);
        accept   = bus.valid_in & ready_q & ~bus.flush;
        fast     = FastSpecial & (div0_in | ovf_in);
        fast_res = div_result(rem_in, bus.is_w, div0_in, ovf_in, a_eff, '0, '0, 1'b0, 1'b0);
        fix_res  = div_result(rem_q, is_w_q, div0_q, ovf_q, a_eff_q, quot, remd,
                              q_neg_q, r_neg_q);
        last_step = is_w_q ? 6'(XLEN / 2 - 1) : 6'(XLEN - 1);
    end

    div_iter u_iter (
        .clk        (clk),
        .load_i     (accept),
        .step_i     (state_q == DivBusy),
        .is_w_i     (bus.is_w),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quot_o     (quot),
        .rem_o      (remd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= DivIdle;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            rem_q    <= 1'b0;
            is_w_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            a_eff_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state_q <= DivIdle;
                ready_q <= 1'b1;
            end else begin
                unique case (state_q)
                    DivIdle, DivDone: begin
                        if (accept) begin
                            rem_q   <= rem_in;
                            is_w_q  <= bus.is_w;
                            div0_q  <= div0_in;
                            ovf_q   <= ovf_in;
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                            a_eff_q <= a_eff;
                            cnt_q   <= '0;
                            if (fast) begin
                                state_q  <= DivDone;
                                ready_q  <= 1'b1;
                                done_q   <= 1'b1;
                                result_q <= fast_res;
                            end else begin
                                state_q <= DivBusy;
                                ready_q <= 1'b0;
                            end
                        end else begin
                            state_q <= DivIdle;
                            ready_q <= 1'b1;
                        end
                    end
                    DivBusy: begin
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == last_step) begin
                            state_q <= DivFix;
                        end
                    end
                    DivFix: begin
                        state_q  <= DivDone;
                        ready_q  <= 1'b1;
                        done_q   <= 1'b1;
                        result_q <= fix_res;
                    end
                    default: begin
                        state_q <= DivIdle;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.ready_out = ready_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_divider.sv
// Directed and randomized checks of the divider against an arithmetic reference model.
module tb_divider;
    import common::*;

`ifdef DIV_FAST_SPECIAL_EN
    localparam int SpecLat = 1;
`else
    localparam int SpecLat = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [63:0] last_res = '0;

    always #5 clk = ~clk;

    divider_if bus ();

    divider #(.XLEN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(alufunc_t f, bit w, logic [63:0] a, logic [63:0] b);
        bit          sg = (f == ALU_DIV) || (f == ALU_REM);
        bit          rm = (f == ALU_REM) || (f == ALU_REMU);
        logic [31:0] r32;
        logic [63:0] r64;
        int          sa, sb;
        longint      la, lb;
        if (w) begin
            sa = int'(a[31:0]);
            sb = int'(b[31:0]);
            if (b[31:0] == 32'h0) r32 = rm ? a[31:0] : 32'hFFFF_FFFF;
            else if (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                r32 = rm ? 32'h0 : 32'h8000_0000;
            else if (sg) r32 = rm ? 32'(sa % sb) : 32'(sa / sb);
            else r32 = rm ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
            return {{32{r32[31]}}, r32};
        end
        la = longint'(a);
        lb = longint'(b);
        if (b == 64'h0) r64 = rm ? a : '1;
        else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) r64 = rm ? 64'h0 : a;
        else if (sg) r64 = rm ? 64'(la % lb) : 64'(la / lb);
        else r64 = rm ? a % b : a / b;
        return r64;
    endfunction

    function automatic int exp_lat(alufunc_t f, bit w, logic [63:0] a, logic [63:0] b);
        bit sg = (f == ALU_DIV) || (f == ALU_REM);
        bit special;
        if (w) special = (b[31:0] == 0) ||
                         (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else   special = (b == 0) || (sg && a == 64'h8000_0000_0000_0000 && b == '1);
        if (special && SpecLat != 0) return SpecLat;
        return w ? 34 : 66;
    endfunction

    // Operands are scrambled right after the accepting edge.
    task automatic start(input alufunc_t f, input bit w, input logic [63:0] a,
                         input logic [63:0] b);
        bus.valid_in = 1'b1;
        bus.func = f;
        bus.is_w = w;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
    endtask

    task automatic wait_done(input int limit, output int lat, output bit held);
        lat = 0;
        held = 1'b1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = i;
                return;
            end
            if (bus.result !== last_res) held = 1'b0;
        end
    endtask

    task automatic run_one(input string tag, input alufunc_t f, input bit w,
                           input logic [63:0] a, input logic [63:0] b);
        int          lat;
        bit          held;
        logic [63:0] exp;
        exp = model(f, w, a, b);
        start(f, w, a, b);
        wait_done(100, lat, held);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(f, w, a, b)));
        chk({tag, "_res"}, bus.result, exp);
        chk({tag, "_rdy"}, 64'(bus.ready_out), 64'd1);
        chk({tag, "_hold_busy"}, 64'(held), 64'd1);
        last_res = exp;
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_hold"}, bus.result, last_res);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) pulses++;
        end
        chk(tag, 64'(pulses), 64'd0);
    endtask

    initial begin
        int          lat;
        bit          held;
        alufunc_t    f;
        bit          w;
        logic [63:0] a, b, exp;
        int          mode;

        bus.valid_in = 1'b0;
        bus.flush = 1'b0;
        bus.func = ALU_DIV;
        bus.is_w = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(bus.ready_out), 64'd1);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result", bus.result, 64'd0);

        run_one("divu_100_7", ALU_DIVU, 1'b0, 64'd100, 64'd7);
        run_one("remw_m7_2", ALU_REM, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        run_one("div_5_0", ALU_DIV, 1'b0, 64'd5, 64'd0);
        run_one("div_ovf", ALU_DIV, 1'b0, 64'h8000_0000_0000_0000, '1);
        run_one("rem_ovf", ALU_REM, 1'b0, 64'h8000_0000_0000_0000, '1);
        run_one("divw_ovf", ALU_DIV, 1'b1, 64'hFFFF_FFFF_8000_0000, '1);
        run_one("remuw_0", ALU_REMU, 1'b1, 64'h0000_0000_9000_0001, 64'h0);

        // Flush ten cycles into an operation.
        start(ALU_DIV, 1'b0, 64'd20, 64'd3);
        watch_no_done("flush_pre", 9);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_ready", 64'(bus.ready_out), 64'd1);
        watch_no_done("flush_no_done", 80);
        run_one("divu_9_3", ALU_DIVU, 1'b0, 64'd9, 64'd3);

        // Flush beats a simultaneous request.
        bus.flush = 1'b1;
        start(ALU_DIVU, 1'b0, 64'd50, 64'd5);
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_vs_valid_ready", 64'(bus.ready_out), 64'd1);
        watch_no_done("flush_vs_valid_no_done", 70);

        // Reset thirty cycles into BUSY.
        start(ALU_DIV, 1'b0, 64'd1000, 64'd7);
        watch_no_done("rst_busy_pre", 29);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy_ready", 64'(bus.ready_out), 64'd1);
        chk("rst_busy_done", 64'(bus.done), 64'd0);
        chk("rst_busy_result", bus.result, 64'd0);
        last_res = '0;
        watch_no_done("rst_busy_no_done", 80);

        // Randomized back-to-back operations; each new request lands in DONE.
        f = alufunc_t'($urandom_range(0, 3));
        w = 1'($urandom_range(0, 1));
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        start(f, w, a, b);
        for (int n = 0; n < 30; n++) begin
            exp = model(f, w, a, b);
            wait_done(100, lat, held);
            chk("rnd_lat", 64'(lat), 64'(exp_lat(f, w, a, b)));
            chk("rnd_res", bus.result, exp);
            chk("rnd_hold", 64'(held), 64'd1);
            last_res = exp;
            if (n == 29) break;
            f = alufunc_t'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            mode = int'($urandom_range(0, 7));
            if (mode == 0) begin
                b = w ? {$urandom, 32'h0} : 64'h0;
            end else if (mode == 1) begin
                b = '1;
                a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
            end else if (mode == 2) begin
                b = 64'($urandom_range(1, 17));
                if ($urandom_range(0, 1) == 1) b = -b;
            end else begin
                b = {$urandom, $urandom} >> $urandom_range(0, 60);
                if (b == 0) b = 64'd3;
            end
            start(f, w, a, b);
        end
        @(negedge clk);
        chk("rnd_final_pulse", 64'(bus.done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameter: XLEN, 64, operand/result width; only 64 is supported.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: valid_in  in  1  operation request from decode/execute boundary.
REQ-006 Port: ready_out  out  1  unit can accept a request this cycle.
REQ-007 Port: flush  in  1  pipeline flush; aborts any operation in flight.
REQ-008 Port: func  in  alufunc_t  one of ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
REQ-009 Port: is_w  in  1  32-bit (ALUW) variant.
REQ-010 Port: a  in  word_t  dividend, already sign/zero-extended upstream for W ops.
REQ-011 Port: b  in  word_t  divisor, same extension rule as a.
REQ-012 Port: done  out  1  result valid, single-cycle pulse.
REQ-013 Port: result  out  word_t  quotient or remainder.

Function
REQ-014 States SHALL be IDLE, BUSY, FIX, DONE.
REQ-015 ready_out SHALL be 1 in IDLE and DONE, 0 in BUSY and FIX.
REQ-016 A request SHALL be accepted on an edge where valid_in=1, ready_out=1 and flush=0; a, b, func and is_w are registered at that edge and may change afterwards.
REQ-017 After acceptance the unit SHALL enter BUSY.
  - BUSY performs one restoring-division step per cycle on operand magnitudes.
  - BUSY lasts 64 cycles, or 32 cycles when is_w=1.
REQ-018 FIX SHALL last 1 cycle and apply sign correction.
  - Quotient is negated when signed and operand signs differ.
  - Remainder takes the sign of the dividend.
REQ-019 done SHALL be 1 for exactly the DONE cycle.
  - This is 66 cycles after the accepting edge, or 34 when is_w=1.
REQ-020 result SHALL hold its last value from DONE until the next done.
REQ-021 A new acceptance during DONE SHALL go directly to BUSY; otherwise DONE SHALL go to IDLE.
REQ-022 Divide by zero SHALL give quotient all-ones and remainder equal to the dividend.
  - For W ops, both results use the 32-bit dividend, sign-extended.
REQ-023 Signed overflow SHALL give quotient equal to the dividend and remainder 0.
  - 64-bit case: 0x8000000000000000 / -1.
  - W case: 0x80000000 / -1.
REQ-024 W ops SHALL use a[31:0] and b[31:0] only, with result = sign-extension of the 32-bit result bit 31.
REQ-025 flush=1 in any state SHALL force IDLE at the next edge, with no done for the aborted operation.
  - flush wins over a simultaneous valid_in.

Reset
REQ-026 While reset=1 the state SHALL become IDLE at the next edge.
  - ready_out=1, done=0 and result=0 after that edge.
REQ-027 Reset during BUSY or FIX SHALL discard the operation with no done.

Configuration
REQ-028 With macro DIV_FAST_SPECIAL_EN defined, the fast path SHALL apply to divide-by-zero and signed overflow.
  - These cases go from acceptance directly to DONE.
  - done is asserted 1 cycle after the accepting edge.
REQ-029 Without DIV_FAST_SPECIAL_EN, special cases SHALL take normal latency (66/34) with results unchanged per REQ-022/023.

Structure
REQ-030 alufunc_t, word_t and the divider state enum SHALL reside in package common.
REQ-031 The unsigned shift-subtract datapath SHALL be one sub-module, div_iter.
  - div_iter covers the quotient/remainder registers and step logic.
  - The divider top level owns the FSM, the sign handling and the special cases.

Verification
REQ-032 DIVU: a=100, b=7, is_w=0 -> done 66 cycles after accept, result=14.
REQ-033 REM with W: a=0xFFFFFFFFFFFFFFF9 (-7), b=2, is_w=1 -> done after 34 cycles, result=0xFFFFFFFFFFFFFFFF (-1).
REQ-034 DIV: a=5, b=0 -> result=0xFFFFFFFFFFFFFFFF.
  - done after 1 cycle with DIV_FAST_SPECIAL_EN, 66 cycles without.
REQ-035 DIV: a=0x8000000000000000, b=-1 -> result=0x8000000000000000; REM of the same operands -> result=0.
REQ-036 Accept DIV 20/3, assert flush at cycle 10 -> no done, ready_out=1 next cycle; a new DIVU 9/3 then returns 3 at normal latency.
REQ-037 Assert reset at cycle 30 of BUSY -> done never pulses, ready_out=1 and result=0 after the edge.
